pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Owns the fetch/execute state bit, program counter, instruction register and return-address stack.
//  Produces state/opcode/eoe for the control decoder and consumes its PS, IL and MP outputs.
//  Sits between instruction memory and the control decoder; the PC is the only instruction-address source.
// PARAMETERS
//  PC_W     8   program-counter / instruction-address width
//  IR_W     16  instruction width: [15:12] opcode, [11:8] eoe/field, [7:0] signed offset
//  RS_DEPTH 4   return-stack entries (power of 2, >=2)
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  imem_data   in   IR_W     instruction word at imem_addr
//  imem_valid  in   1        imem_data valid this cycle
//  ps          in   2        PC select from decoder: 00 hold/halt, 01 +1, 10 +offset, 11 return
//  il          in   1        instruction-load enable from decoder
//  mp          in   1        jump-and-link request from decoder
//  imem_addr   out  PC_W     = pc
//  imem_req    out  1        high in FETCH
//  state       out  1        0 = FETCH, 1 = EXEC (drives decoder state input)
//  opcode      out  4        ir[15:12]
//  eoe         out  4        ir[11:8]
//  link_pc     out  PC_W     pc+1, registered-file write data when mp
//  halted      out  1        high in HALT
//  rs_ovf      out  1        sticky: push attempted while stack full
//  rs_unf      out  1        sticky: pop attempted while stack empty
// BEHAVIOUR
//  Reset: pc=0, ir=0, FSM=FETCH, sp=0 (empty), halted=0, rs_ovf=0, rs_unf=0; stack contents don't-care.
//  FSM states FETCH, EXEC, HALT; state output = 1 only in EXEC (HALT drives 0, imem_req 0).
//  FETCH: imem_req=1. If imem_valid && il: ir<=imem_data, -> EXEC. Else stay in FETCH, ir and pc hold.
//  EXEC (exactly 1 cycle); priority mp > ps:
//   mp=1: push pc+1; pc<=pc+sext(ir[7:0]); -> FETCH. ps is ignored.
//   ps=01: pc<=pc+1 -> FETCH.  ps=10: pc<=pc+sext(ir[7:0]) -> FETCH.
//   ps=11: pop; pc<=top -> FETCH. If empty: rs_unf<=1, pc<=pc+1, sp unchanged.
//   ps=00: pc holds, -> HALT.
//  HALT: absorbing; all registers hold, il/ps/mp ignored; only rst exits.
//  Arithmetic: modulo 2^PC_W; 0xFF+1 -> 0x00; 0x02+sext(0xFC) -> 0xFE. Offset sign-extended from bit 7.
//  Push when full (sp==RS_DEPTH): rs_ovf<=1, entry dropped, sp unchanged, jump still taken.
//  Stack is LIFO; push and pop never coincide (mp has priority).
//  link_pc is combinational pc+1, valid during EXEC.
//  rst overrides everything in the same edge, including mid-EXEC and HALT.
//  Fetch latency: 1 cycle after imem_valid&&il; instruction period = 2 cycles with no wait states.
// STRUCTURE
//  Shared package cpu_pkg: PS_HOLD/PS_INC/PS_BR/PS_RET codes, opcode field positions, FSM state codes.
//  Sub-module return_stack (RS_DEPTH x PC_W; push, pop, top, full, empty); pc_fetch_unit holds FSM, pc, ir, flags.
// TESTING
//  1. Reset, imem_valid=1, il=1, ps=01 each EXEC -> pc 0,1,2,3 on successive FETCH; state toggles 0/1.
//  2. imem_valid low 3 cycles in FETCH -> state stays 0, ir/pc hold; loads on the 4th cycle.
//  3. pc=0x10, ir[7:0]=0x05, mp=1 -> pc=0x15, top=0x11; later ps=11 -> pc=0x11, stack empty.
//  4. pc=0xFF, ps=01 -> pc=0x00; pc=0x02, ps=10, off=0xFC -> pc=0xFE.
//  5. Five mp pushes with RS_DEPTH=4 -> rs_ovf=1 after the 5th; ps=11 on empty stack -> rs_unf=1, pc+1.
//  6. ps=00 in EXEC -> halted=1, pc frozen for 10 cycles; rst=1 for 1 cycle -> pc=0, state=FETCH, flags clear.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit.
// Contents: PC-select codes from the control decoder, instruction field
// positions, and the fetch FSM state encoding.
package pc_fetch_unit_pkg;

  // PC select codes driven by the control decoder
  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_BR   = 2'b10,
    PS_RET  = 2'b11
  } ps_e;

  // Instruction field positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int EOE_MSB = 11;
  localparam int EOE_LSB = 8;
  localparam int OFF_MSB = 7;
  localparam int OFF_LSB = 0;

  // Fetch/execute FSM states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } fsm_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bus between the fetch unit, instruction memory and control decoder.
//   imem_data/imem_valid : instruction word from memory
//   ps/il/mp             : decoder controls (PC select, IR load, jump-and-link)
//   imem_addr/imem_req   : instruction address and request
//   state/opcode/eoe     : decoder inputs
//   link_pc              : return address written on jump-and-link
//   halted/rs_ovf/rs_unf : status flags
// master = fetch unit side, slave = environment side.
interface pc_fetch_unit_if #(
  parameter int PC_W = 8,
  parameter int IR_W = 16
);
  logic [IR_W-1:0] imem_data;
  logic            imem_valid;
  logic [1:0]      ps;
  logic            il;
  logic            mp;
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            state;
  logic [3:0]      opcode;
  logic [3:0]      eoe;
  logic [PC_W-1:0] link_pc;
  logic            halted;
  logic            rs_ovf;
  logic            rs_unf;

  modport master (
    input  imem_data, imem_valid, ps, il, mp,
    output imem_addr, imem_req, state, opcode, eoe, link_pc,
           halted, rs_ovf, rs_unf
  );

  modport slave (
    output imem_data, imem_valid, ps, il, mp,
    input  imem_addr, imem_req, state, opcode, eoe, link_pc,
           halted, rs_ovf, rs_unf
  );
endinterface

// File: rtl/pc_fetch_unit_return_stack.sv
// LIFO return-address stack, RS_DEPTH entries of PC_W bits.
//   clk, rst  : clock, synchronous active-high reset (empties the stack)
//   i_push    : write i_data on top (ignored when full)
//   i_pop     : discard top entry (ignored when empty)
//   i_data    : push data
//   o_top     : current top entry (meaningless when empty)
//   o_full    : RS_DEPTH entries held
//   o_empty   : no entries held
module return_stack #(
  parameter int PC_W     = 8,
  parameter int RS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_data,
  output logic [PC_W-1:0] o_top,
  output logic            o_full,
  output logic            o_empty
);
  // One extra bit so that sp can count 0..RS_DEPTH inclusive
  localparam int SP_W = $clog2(RS_DEPTH) + 1;

  logic [PC_W-1:0] r_mem [RS_DEPTH];
  logic [SP_W-1:0] r_sp;
  logic [SP_W-1:0] w_sp_m1;

  assign w_sp_m1 = r_sp - SP_W'(1);
  assign o_full  = (r_sp == SP_W'(RS_DEPTH));
  assign o_empty = (r_sp == '0);
  assign o_top   = r_mem[w_sp_m1[SP_W-2:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= w_sp_m1;
    end
  end

  // Contents need no reset; only sp defines validity
  always_ff @(posedge clk) begin
    if (!rst && i_push && !o_full) begin
      r_mem[r_sp[SP_W-2:0]] <= i_data;
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch/execute sequencer: owns the FSM state, program counter, instruction
// register and return-address stack.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : master modport of pc_fetch_unit_if (memory + decoder signals)
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int IR_W     = 16,
  parameter int RS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  pc_fetch_unit_if.master    bus
);
  fsm_e            r_state;
  logic [PC_W-1:0] r_pc;
  logic [IR_W-1:0] r_ir;
  logic            r_ovf;
  logic            r_unf;

  logic [PC_W-1:0] w_off;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_br;
  logic [PC_W-1:0] w_top;
  logic            w_full;
  logic            w_empty;
  logic            w_exec;
  logic            w_push;
  logic            w_pop;

  // Offset is sign-extended from bit 7; sums wrap modulo 2^PC_W
  assign w_off    = PC_W'(signed'(r_ir[OFF_MSB:OFF_LSB]));
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_br  = r_pc + w_off;

  assign w_exec = (r_state == ST_EXEC);
  // mp wins over ps, so push and pop are mutually exclusive
  assign w_push = w_exec && bus.mp;
  assign w_pop  = w_exec && !bus.mp && (ps_e'(bus.ps) == PS_RET) && !w_empty;

  return_stack #(
    .PC_W     (PC_W),
    .RS_DEPTH (RS_DEPTH)
  ) u_rs (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.imem_valid && bus.il) begin
            r_ir    <= bus.imem_data;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= ST_FETCH;
          if (bus.mp) begin
            r_pc <= w_pc_br;
            if (w_full) r_ovf <= 1'b1;
          end else begin
            case (ps_e'(bus.ps))
              PS_INC: r_pc <= w_pc_inc;
              PS_BR:  r_pc <= w_pc_br;
              PS_RET: begin
                if (w_empty) begin
                  r_unf <= 1'b1;
                  r_pc  <= w_pc_inc;
                end else begin
                  r_pc <= w_top;
                end
              end
              default: r_state <= ST_HALT;
            endcase
          end
        end
        ST_HALT: ;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.imem_req  = (r_state == ST_FETCH);
  assign bus.state     = w_exec;
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.opcode    = r_ir[OPC_MSB:OPC_LSB];
  assign bus.eoe       = r_ir[EOE_MSB:EOE_LSB];
  assign bus.link_pc   = w_pc_inc;
  assign bus.rs_ovf    = r_ovf;
  assign bus.rs_unf    = r_unf;
endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.PC_W(8), .IR_W(16)) bus ();

  pc_fetch_unit #(.PC_W(8), .IR_W(16), .RS_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = fetch, 1 = exec, 2 = halt
  int          m_st  = 0;
  int          m_pc  = 0;
  logic [15:0] m_ir  = '0;
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  int          m_stk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input bit il, input logic [1:0] ps,
                            input bit mp, input logic [15:0] d, input bit r);
    int off;
    if (r) begin
      m_st = 0; m_pc = 0; m_ir = '0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
      return;
    end
    off = int'($signed(m_ir[7:0]));
    case (m_st)
      0: if (v && il) begin m_ir = d; m_st = 1; end
      1: begin
        m_st = 0;
        if (mp) begin
          if (m_stk.size() == 4) m_ovf = 1;
          else m_stk.push_back((m_pc + 1) & 255);
          m_pc = (m_pc + off) & 255;
        end else begin
          case (ps)
            2'd1: m_pc = (m_pc + 1) & 255;
            2'd2: m_pc = (m_pc + off) & 255;
            2'd3: begin
              if (m_stk.size() == 0) begin
                m_unf = 1;
                m_pc  = (m_pc + 1) & 255;
              end else begin
                m_pc = m_stk.pop_back();
              end
            end
            default: m_st = 2;
          endcase
        end
      end
      default: ;
    endcase
  endtask

  // Called at a falling edge: drive, check combinational link_pc,
  // clock once, update model, then check all outputs at the next falling edge.
  task automatic step(input bit v, input bit il, input logic [1:0] ps,
                      input bit mp, input logic [15:0] d, input bit r);
    bus.imem_valid = v;
    bus.il         = il;
    bus.ps         = ps;
    bus.mp         = mp;
    bus.imem_data  = d;
    rst            = r;
    if (m_st == 1) chk("link_pc", bus.link_pc, (m_pc + 1) & 255);
    @(posedge clk);
    model_edge(v, il, ps, mp, d, r);
    @(negedge clk);
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("state",     bus.state,     m_st == 1);
    chk("imem_req",  bus.imem_req,  m_st == 0);
    chk("halted",    bus.halted,    m_st == 2);
    chk("opcode",    bus.opcode,    m_ir[15:12]);
    chk("eoe",       bus.eoe,       m_ir[11:8]);
    chk("rs_ovf",    bus.rs_ovf,    m_ovf);
    chk("rs_unf",    bus.rs_unf,    m_unf);
  endtask

  task automatic instr(input logic [15:0] d, input logic [1:0] ps, input bit mp);
    step(1, 1, 2'd0, 0, d, 0);
    step(1, 0, ps, mp, 16'hDEAD, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 2'd0, 0, 16'h0, 1);
    rst = 1'b0;
  endtask

  initial begin
    bus.imem_valid = 1'b0;
    bus.il         = 1'b0;
    bus.ps         = 2'd0;
    bus.mp         = 1'b0;
    bus.imem_data  = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_pc", bus.imem_addr, 8'h00);
    chk("rst_state", bus.state, 1'b0);

    // Sequential fetch with ps=01
    for (int i = 0; i < 4; i++) begin
      instr(16'h1200 | 16'(i), 2'd1, 0);
      chk("t1_pc", bus.imem_addr, 32'(i + 1));
    end

    // Wait states in FETCH
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'd1, 0, 16'hFFFF, 0);
      chk("t2_wait_state", bus.state, 1'b0);
      chk("t2_wait_pc", bus.imem_addr, 8'h04);
    end
    step(1, 1, 2'd1, 0, 16'h2A07, 0);
    chk("t2_load_state", bus.state, 1'b1);
    chk("t2_opcode", bus.opcode, 4'h2);
    step(1, 0, 2'd1, 0, 16'h0, 0);
    chk("t2_pc", bus.imem_addr, 8'h05);

    // Jump-and-link then return
    do_reset();
    instr(16'h0010, 2'd2, 0);
    chk("t3_pc10", bus.imem_addr, 8'h10);
    instr(16'h3405, 2'd0, 1);
    chk("t3_jal", bus.imem_addr, 8'h15);
    instr(16'h0000, 2'd3, 0);
    chk("t3_ret", bus.imem_addr, 8'h11);
    chk("t3_unf", bus.rs_unf, 1'b0);

    // Wraparound arithmetic
    do_reset();
    instr(16'h00FF, 2'd2, 0);
    chk("t4_ff", bus.imem_addr, 8'hFF);
    instr(16'h0000, 2'd1, 0);
    chk("t4_wrap", bus.imem_addr, 8'h00);
    instr(16'h0000, 2'd1, 0);
    instr(16'h0000, 2'd1, 0);
    instr(16'h00FC, 2'd2, 0);
    chk("t4_neg", bus.imem_addr, 8'hFE);

    // Overflow / underflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      instr(16'h0001, 2'd1, 1);
      chk("t5_ovf", bus.rs_ovf, (i == 4));
    end
    chk("t5_pc", bus.imem_addr, 8'h05);
    for (int i = 0; i < 4; i++) begin
      instr(16'h0000, 2'd3, 0);
      chk("t5_pop", bus.imem_addr, 32'(4 - i));
    end
    instr(16'h0000, 2'd3, 0);
    chk("t5_unf", bus.rs_unf, 1'b1);
    chk("t5_unf_pc", bus.imem_addr, 8'h02);

    // Halt is absorbing until reset
    do_reset();
    instr(16'h0000, 2'd1, 0);
    instr(16'h0000, 2'd0, 0);
    chk("t6_halted", bus.halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 2'($urandom_range(0, 3)), 1, 16'($urandom), 0);
      chk("t6_frozen", bus.imem_addr, 8'h01);
    end
    do_reset();
    chk("t6_rst_pc", bus.imem_addr, 8'h00);
    chk("t6_rst_halt", bus.halted, 1'b0);
    chk("t6_rst_state", bus.state, 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit r;
      r = (m_st == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 4) != 0),
           ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
           bit'($urandom_range(0, 5) == 0), 16'($urandom), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
